// File: rtl/sevseg_bin_decoder.sv
// Seven-segment pattern to binary decoder with stability filter, valid/ready handshake
// and sticky overrun flag. Define SEVSEG_HEX_EN to also accept the hex glyphs A..F.
module sevseg_bin_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       ready,
  output logic [3:0] D,
  output logic       valid,
  output logic       err,
  output logic       ovf
);

  localparam logic [1:0] StIdle       = 2'd0;
  localparam logic [1:0] StHold       = 2'd1;
  localparam logic [1:0] StWaitChange = 2'd2;

  localparam logic [3:0] StableCnt = 4'(STABLE_CYC);

  logic [6:0] seg_d, seg_q;
  logic [6:0] rep_d, rep_q;
  logic [3:0] cnt_d, cnt_q;
  logic [1:0] state_d, state_q;
  logic [3:0] d_d, d_q;
  logic       valid_d, valid_q;
  logic       err_d, err_q;
  logic       ovf_d, ovf_q;
  logic       stable;
  logic [4:0] dec;

  // Returns {err, value}; unknown patterns map to value 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1111110: r = {1'b0, 4'h0};
      7'b0110000: r = {1'b0, 4'h1};
      7'b1101101: r = {1'b0, 4'h2};
      7'b1111001: r = {1'b0, 4'h3};
      7'b0110011: r = {1'b0, 4'h4};
      7'b1011011: r = {1'b0, 4'h5};
      7'b1011111: r = {1'b0, 4'h6};
      7'b1110000: r = {1'b0, 4'h7};
      7'b1111111: r = {1'b0, 4'h8};
      7'b1111011: r = {1'b0, 4'h9};
`ifdef SEVSEG_HEX_EN
      7'b1110111: r = {1'b0, 4'hA};
      7'b0011111: r = {1'b0, 4'hB};
      7'b1001110: r = {1'b0, 4'hC};
      7'b0111101: r = {1'b0, 4'hD};
      7'b1001111: r = {1'b0, 4'hE};
      7'b1000111: r = {1'b0, 4'hF};
`endif
      default:    r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  assign seg_d  = {a, b, c, d, e, f, g};
  assign stable = (cnt_q == StableCnt);
  assign dec    = decode(seg_q);

  always_comb begin
    if (seg_d != seg_q) begin
      cnt_d = 4'd1;
    end else if (cnt_q < StableCnt) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    d_d     = d_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    rep_d   = rep_q;
    case (state_q)
      StIdle: begin
        if (stable && (seg_q != 7'd0)) begin
          d_d     = dec[3:0];
          err_d   = dec[4];
          valid_d = 1'b1;
          rep_d   = seg_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = StWaitChange;
        end else if (stable && (seg_q != rep_q)) begin
          // Dropped pattern becomes the reference so it is not reported after the handshake.
          ovf_d = 1'b1;
          rep_d = seg_q;
        end
      end
      StWaitChange: begin
        if (seg_q != rep_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= 7'd0;
      rep_q   <= 7'd0;
      cnt_q   <= 4'd0;
      state_q <= StIdle;
      d_q     <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign D     = d_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_sevseg_bin_decoder.sv
// Self-checking bench for sevseg_bin_decoder: directed scenarios plus randomized
// segment streams compared against a behavioural model built on a sample history queue.
module tb_sevseg_bin_decoder;

  localparam int unsigned S = 4;

  logic       clk;
  logic       rst_n;
  logic       a, b, c, d, e, f, g;
  logic       ready;
  logic [3:0] dout;
  logic       valid;
  logic       err;
  logic       ovf;

  int n_cmp;
  int n_bad;

  sevseg_bin_decoder #(
    .STABLE_CYC(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .e    (e),
    .f    (f),
    .g    (g),
    .ready(ready),
    .D    (dout),
    .valid(valid),
    .err  (err),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [6:0] hist[$];
  logic [6:0] lut[16];
  int         n_legal;
  int         m_run;
  logic [6:0] m_seg;
  logic [6:0] m_rep;
  bit         m_valid;
  bit         m_idle;
  bit         m_ovf;
  logic [3:0] m_d;
  bit         m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_run   = 0;
    m_seg   = 7'd0;
    m_rep   = 7'd0;
    m_valid = 0;
    m_idle  = 1;
    m_ovf   = 0;
    m_d     = 4'd0;
    m_err   = 0;
  endtask

  // Models one rising edge: acts on what was sampled so far, then records the new sample.
  task automatic model_edge(input logic [6:0] p, input bit r);
    bit held;
    int k;
    held = (m_run >= S);
    if (m_valid) begin
      if (r) begin
        m_valid = 0;
      end else if (held && m_seg != m_rep) begin
        m_ovf = 1;
        m_rep = m_seg;
      end
    end else if (m_idle) begin
      if (held && m_seg != 7'd0) begin
        m_d   = 4'd0;
        m_err = 1;
        for (int i = 0; i < n_legal; i++) begin
          if (lut[i] == m_seg) begin
            m_d   = 4'(i);
            m_err = 0;
          end
        end
        m_valid = 1;
        m_rep   = m_seg;
        m_idle  = 0;
      end
    end else if (m_seg != m_rep) begin
      m_idle = 1;
    end
    hist.push_back(p);
    if (hist.size() > 32) void'(hist.pop_front());
    m_seg = p;
    m_run = 0;
    k = hist.size() - 1;
    while (k >= 0 && hist[k] == p && m_run < S) begin
      m_run++;
      k--;
    end
  endtask

  task automatic compare_outputs(input string tag);
    check_eq({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check_eq({tag, ".D"}, 32'(dout), 32'(m_d));
    check_eq({tag, ".err"}, 32'(err), 32'(m_err));
    check_eq({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  // Check outputs of the previous edge, then drive the inputs for the next one.
  task automatic cycle(input string tag, input logic [6:0] p, input bit r);
    @(negedge clk);
    compare_outputs(tag);
    {a, b, c, d, e, f, g} = p;
    ready = r;
    model_edge(p, r);
  endtask

  task automatic hold(input string tag, input logic [6:0] p, input bit r, input int n);
    for (int i = 0; i < n; i++) cycle(tag, p, r);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs({tag, ".async"});
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] pool[20];
    logic [6:0] p;
    int         len;

    lut[0]  = 7'b1111110; lut[1]  = 7'b0110000; lut[2]  = 7'b1101101; lut[3]  = 7'b1111001;
    lut[4]  = 7'b0110011; lut[5]  = 7'b1011011; lut[6]  = 7'b1011111; lut[7]  = 7'b1110000;
    lut[8]  = 7'b1111111; lut[9]  = 7'b1111011; lut[10] = 7'b1110111; lut[11] = 7'b0011111;
    lut[12] = 7'b1001110; lut[13] = 7'b0111101; lut[14] = 7'b1001111; lut[15] = 7'b1000111;
`ifdef SEVSEG_HEX_EN
    n_legal = 16;
`else
    n_legal = 10;
`endif
    for (int i = 0; i < 16; i++) pool[i] = lut[i];
    pool[16] = 7'b0000000;
    pool[17] = 7'b0000000;
    pool[18] = 7'b1010101;
    pool[19] = 7'b0000001;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    {a, b, c, d, e, f, g} = 7'd0;
    ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_outputs("reset");
    #1 rst_n = 1'b1;

    // Single legal digit, one transfer, no repeat while held
    hold("digit1", 7'b0110000, 1'b1, 6);
    hold("digit1_tail", 7'b0110000, 1'b1, 4);
    hold("blank", 7'b0000000, 1'b1, 3);

    // Glitch of 3 for two samples, then 0 held
    hold("glitch3", 7'b1111001, 1'b1, 2);
    hold("digit0", 7'b1111110, 1'b1, 7);
    hold("blank", 7'b0000000, 1'b1, 3);

    // Hex glyph A and a plainly illegal pattern
    hold("hexA", 7'b1110111, 1'b1, 7);
    hold("blank", 7'b0000000, 1'b1, 3);
    hold("illegal", 7'b1010101, 1'b1, 7);
    hold("blank", 7'b0000000, 1'b1, 3);

    // Overrun: 5 pending, 8 arrives and is dropped
    hold("pend5", 7'b1011011, 1'b0, 6);
    hold("ovr8", 7'b1111111, 1'b0, 5);
    hold("ack5", 7'b1111111, 1'b1, 5);
    hold("blank", 7'b0000000, 1'b1, 3);
    hold("again8", 7'b1111111, 1'b1, 6);

    // Reset in the middle of HOLD with ovf set
    hold("blank", 7'b0000000, 1'b1, 2);
    hold("pend5b", 7'b1011011, 1'b0, 6);
    hold("ovr1", 7'b0110000, 1'b0, 5);
    pulse_reset("midhold");
    hold("digit7", 7'b1110000, 1'b1, 7);

    // Randomized pattern streams with random ready and occasional resets
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 4) == 0) p = 7'($urandom_range(0, 127));
      else p = pool[$urandom_range(0, 19)];
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) cycle("rand", p, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_rst");
    end

    @(negedge clk);
    compare_outputs("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
